// File: rtl/uc_bloco_if.sv
// Instruction handshake bundle between an instruction source and the
// uc_bloco control unit. The master offers an encoded instruction; the
// slave (uc_bloco) raises instr_ready only when it can take one.
interface uc_bloco_if #(
  parameter int end_registros = 4
);
  localparam int INSTR_W = 5 + 2 * end_registros + 3;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/uc_bloco.sv
// uc_bloco: control unit sequencing the register bank / ULA / flag register
// datapath. It takes one instruction at a time, checks its flag condition,
// then walks EXECUTE and WRITEBACK phases, or issues flag / register-bank
// clear pulses. Every datapath-facing output is registered and is computed
// from the next state, so the outputs line up with the state they belong to.
module uc_bloco #(
  parameter int end_registros = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  uc_bloco_if.slave                bus,
  input  logic                     clear_regs,
  input  logic [3:0]               flags_zcso,
  output logic [end_registros-1:0] sel_sa,
  output logic [end_registros-1:0] sel_sb,
  output logic [4:0]               controle_operacao,
  output logic                     en,
  output logic                     hab_escrita,
  output logic                     reset_ban_registros,
  output logic                     reset_flags,
  output logic                     busy,
  output logic                     done,
  output logic                     skipped,
  output logic [7:0]               retired
);

  localparam int INSTR_W = 5 + 2 * end_registros + 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_CLRF      = 3'd4,
    ST_CLRR      = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // Condition code 3'b111 is not a test; it selects the flag-clear sequence.
  localparam logic [2:0] COND_CLR_FLAGS = 3'b111;

  // Returns 1 when the condition code holds for the given ZCSO flags.
  // Codes 110 (never) and 111 (flag clear) both report false here.
  function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] fl);
    logic r;
    case (cond)
      3'b000:  r = 1'b1;
      3'b001:  r = fl[3];
      3'b010:  r = ~fl[3];
      3'b011:  r = fl[2];
      3'b100:  r = fl[1];
      3'b101:  r = fl[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t                   state_q, state_d;
  logic [INSTR_W-1:0]       instr_q, instr_d;
  logic [end_registros-1:0] sel_sa_q, sel_sa_d;
  logic [end_registros-1:0] sel_sb_q, sel_sb_d;
  logic [4:0]               op_q, op_d;
  logic                     en_q, en_d;
  logic                     hab_escrita_q, hab_escrita_d;
  logic                     reset_ban_q, reset_ban_d;
  logic                     reset_flags_q, reset_flags_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     skipped_q, skipped_d;
  logic [7:0]               retired_q, retired_d;
  logic                     skip_now;

  // Fields of the latched instruction: op, sa, sb, cond from MSB down.
  logic [4:0]               f_op;
  logic [end_registros-1:0] f_sa;
  logic [end_registros-1:0] f_sb;
  logic [2:0]               f_cond;

  assign f_op   = instr_q[INSTR_W-1 -: 5];
  assign f_sa   = instr_q[3 + 2 * end_registros - 1 -: end_registros];
  assign f_sb   = instr_q[3 + end_registros - 1 -: end_registros];
  assign f_cond = instr_q[2:0];

  // Ready is combinational so it reads 1 in the very first cycle after reset
  // drops, and never while reset is held.
  assign bus.instr_ready = (state_q == ST_IDLE) && !reset;

  // Next-state logic and instruction capture; clear_regs wins over instr_valid.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    skip_now = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_regs) begin
          state_d = ST_CLRR;
        end else if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (f_cond == COND_CLR_FLAGS) begin
          state_d = ST_CLRF;
        end else if (cond_true(f_cond, flags_zcso)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d  = ST_DONE;
          skip_now = 1'b1;
        end
      end
      ST_EXECUTE:   state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = ST_DONE;
      ST_CLRF:      state_d = ST_DONE;
      ST_CLRR:      state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming state, plus skipped/retired bookkeeping.
  always_comb begin
    sel_sa_d      = {end_registros{1'b0}};
    sel_sb_d      = {end_registros{1'b0}};
    op_d          = 5'd0;
    en_d          = 1'b0;
    hab_escrita_d = 1'b0;
    reset_ban_d   = 1'b0;
    reset_flags_d = 1'b0;
    done_d        = 1'b0;
    busy_d        = (state_d != ST_IDLE);
    skipped_d     = skipped_q;
    case (state_d)
      ST_EXECUTE: begin
        sel_sa_d = f_sa;
        sel_sb_d = f_sb;
        op_d     = f_op;
        en_d     = 1'b1;
      end
      ST_WRITEBACK: begin
        sel_sa_d      = f_sa;
        sel_sb_d      = f_sb;
        op_d          = f_op;
        en_d          = 1'b1;
        hab_escrita_d = 1'b1;
      end
      ST_CLRF: reset_flags_d = 1'b1;
      ST_CLRR: reset_ban_d   = 1'b1;
      ST_DONE: begin
        done_d    = 1'b1;
        skipped_d = skip_now;
      end
      default: busy_d = (state_d != ST_IDLE);
    endcase

    // Only a completed writeback retires an instruction; 8-bit wrap is intended.
    if (state_q == ST_WRITEBACK) begin
      retired_d = retired_q + 8'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  // State, instruction register and registered outputs; reset clears all of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      instr_q       <= {INSTR_W{1'b0}};
      sel_sa_q      <= {end_registros{1'b0}};
      sel_sb_q      <= {end_registros{1'b0}};
      op_q          <= 5'd0;
      en_q          <= 1'b0;
      hab_escrita_q <= 1'b0;
      reset_ban_q   <= 1'b0;
      reset_flags_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      skipped_q     <= 1'b0;
      retired_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      sel_sa_q      <= sel_sa_d;
      sel_sb_q      <= sel_sb_d;
      op_q          <= op_d;
      en_q          <= en_d;
      hab_escrita_q <= hab_escrita_d;
      reset_ban_q   <= reset_ban_d;
      reset_flags_q <= reset_flags_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      skipped_q     <= skipped_d;
      retired_q     <= retired_d;
    end
  end

  assign sel_sa              = sel_sa_q;
  assign sel_sb              = sel_sb_q;
  assign controle_operacao   = op_q;
  assign en                  = en_q;
  assign hab_escrita         = hab_escrita_q;
  assign reset_ban_registros = reset_ban_q;
  assign reset_flags         = reset_flags_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign skipped             = skipped_q;
  assign retired             = retired_q;

endmodule

// File: tb/tb_uc_bloco.sv
// Directed testbench for uc_bloco: outputs are sampled on the falling edge,
// inputs are driven on the falling edge, expectations are hand-derived.
module tb_uc_bloco;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_regs;
  logic [3:0] flags_zcso;
  logic [3:0] sel_sa;
  logic [3:0] sel_sb;
  logic [4:0] controle_operacao;
  logic       en;
  logic       hab_escrita;
  logic       reset_ban_registros;
  logic       reset_flags;
  logic       busy;
  logic       done;
  logic       skipped;
  logic [7:0] retired;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_retired = 8'd0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  int         last_acc = -1;

  uc_bloco_if #(.end_registros(4)) bus ();

  uc_bloco #(.end_registros(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .bus                 (bus),
    .clear_regs          (clear_regs),
    .flags_zcso          (flags_zcso),
    .sel_sa              (sel_sa),
    .sel_sb              (sel_sb),
    .controle_operacao   (controle_operacao),
    .en                  (en),
    .hab_escrita         (hab_escrita),
    .reset_ban_registros (reset_ban_registros),
    .reset_flags         (reset_flags),
    .busy                (busy),
    .done                (done),
    .skipped             (skipped),
    .retired             (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full instruction starting at a falling edge in IDLE; ends in IDLE.
  task automatic run_instr(input string tag, input logic [4:0] op, input logic [3:0] sa,
                           input logic [3:0] sb, input logic [2:0] cond,
                           input logic [3:0] fl, input bit ex);
    flags_zcso      = fl;
    bus.instr       = {op, sa, sb, cond};
    bus.instr_valid = 1'b1;
    #1;
    chk($sformatf("%s.c0_ready", tag), bus.instr_ready, 32'd1);
    @(negedge clk); // cycle 1: DECODE
    bus.instr_valid = 1'b0;
    bus.instr       = 16'hFFFF;
    chk($sformatf("%s.c1_busy", tag), busy, 32'd1);
    chk($sformatf("%s.c1_ready", tag), bus.instr_ready, 32'd0);
    chk($sformatf("%s.c1_en", tag), en, 32'd0);
    @(negedge clk); // cycle 2
    if (ex) begin
      chk($sformatf("%s.c2_en", tag), en, 32'd1);
      chk($sformatf("%s.c2_hab", tag), hab_escrita, 32'd0);
      chk($sformatf("%s.c2_sa", tag), sel_sa, {28'd0, sa});
      chk($sformatf("%s.c2_sb", tag), sel_sb, {28'd0, sb});
      chk($sformatf("%s.c2_op", tag), controle_operacao, {27'd0, op});
      @(negedge clk); // cycle 3: WRITEBACK
      chk($sformatf("%s.c3_en", tag), en, 32'd1);
      chk($sformatf("%s.c3_hab", tag), hab_escrita, 32'd1);
      chk($sformatf("%s.c3_sa", tag), sel_sa, {28'd0, sa});
      chk($sformatf("%s.c3_sb", tag), sel_sb, {28'd0, sb});
      chk($sformatf("%s.c3_op", tag), controle_operacao, {27'd0, op});
      chk($sformatf("%s.c3_done", tag), done, 32'd0);
      @(negedge clk); // cycle 4: DONE
      exp_retired = exp_retired + 8'd1;
      chk($sformatf("%s.c4_done", tag), done, 32'd1);
      chk($sformatf("%s.c4_skip", tag), skipped, 32'd0);
      chk($sformatf("%s.c4_hab", tag), hab_escrita, 32'd0);
      chk($sformatf("%s.c4_en", tag), en, 32'd0);
      chk($sformatf("%s.c4_sa", tag), sel_sa, 32'd0);
      chk($sformatf("%s.c4_ret", tag), retired, {24'd0, exp_retired});
    end else begin
      chk($sformatf("%s.c2_done", tag), done, 32'd1);
      chk($sformatf("%s.c2_skip", tag), skipped, 32'd1);
      chk($sformatf("%s.c2_en", tag), en, 32'd0);
      chk($sformatf("%s.c2_hab", tag), hab_escrita, 32'd0);
      chk($sformatf("%s.c2_ret", tag), retired, {24'd0, exp_retired});
    end
    @(negedge clk); // back in IDLE
    chk($sformatf("%s.end_done", tag), done, 32'd0);
    chk($sformatf("%s.end_ready", tag), bus.instr_ready, 32'd1);
    chk($sformatf("%s.end_busy", tag), busy, 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    clear_regs      = 1'b0;
    flags_zcso      = 4'b0000;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.ready", bus.instr_ready, 32'd0);
    chk("rst.outs", {20'd0, en, hab_escrita, reset_ban_registros, reset_flags,
                     busy, done, skipped, controle_operacao}, 32'd0);
    chk("rst.sel", {24'd0, sel_sa, sel_sb}, 32'd0);
    chk("rst.ret", retired, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst.ready", bus.instr_ready, 32'd1);
    chk("post_rst.busy", busy, 32'd0);

    // Conditions: always / Z / !Z / C / S / O / never
    run_instr("exec1",   5'h01, 4'd3, 4'd4,   3'b000, 4'b0000, 1'b1);
    run_instr("z_skip",  5'h02, 4'd1, 4'd2,   3'b001, 4'b0000, 1'b0);
    run_instr("z_exec",  5'h02, 4'd1, 4'd2,   3'b001, 4'b1000, 1'b1);
    run_instr("nz_skip", 5'h04, 4'd7, 4'd8,   3'b010, 4'b1000, 1'b0);
    run_instr("c_exec",  5'h05, 4'd9, 4'd10,  3'b011, 4'b0100, 1'b1);
    run_instr("s_skip",  5'h06, 4'd11, 4'd12, 3'b100, 4'b1101, 1'b0);
    run_instr("o_exec",  5'h1E, 4'd15, 4'd0,  3'b101, 4'b0001, 1'b1);
    run_instr("nop",     5'h07, 4'd2, 4'd3,   3'b110, 4'b1111, 1'b0);

    // Flag clear (cond 111); skipped is 1 beforehand, must read 0 at done
    flags_zcso      = 4'b1111;
    bus.instr       = {5'h1F, 4'hA, 4'hB, 3'b111};
    bus.instr_valid = 1'b1;
    #1;
    chk("clrf.c0_ready", bus.instr_ready, 32'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("clrf.c1_rf", reset_flags, 32'd0);
    chk("clrf.c1_busy", busy, 32'd1);
    @(negedge clk);
    chk("clrf.c2_rf", reset_flags, 32'd1);
    chk("clrf.c2_done", done, 32'd0);
    chk("clrf.c2_en", en, 32'd0);
    @(negedge clk);
    chk("clrf.c3_done", done, 32'd1);
    chk("clrf.c3_skip", skipped, 32'd0);
    chk("clrf.c3_rf", reset_flags, 32'd0);
    chk("clrf.c3_ret", retired, {24'd0, exp_retired});
    @(negedge clk);
    chk("clrf.c4_ready", bus.instr_ready, 32'd1);

    // Register clear together with instr_valid: clear wins, instr dropped
    run_instr("nop2", 5'h08, 4'd1, 4'd1, 3'b110, 4'b0000, 1'b0);
    clear_regs      = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr       = {5'h01, 4'd1, 4'd1, 3'b000};
    #1;
    chk("clrr.c0_ready", bus.instr_ready, 32'd1);
    @(negedge clk);
    clear_regs      = 1'b0;
    bus.instr_valid = 1'b0;
    chk("clrr.c1_rb", reset_ban_registros, 32'd1);
    chk("clrr.c1_busy", busy, 32'd1);
    chk("clrr.c1_en", en, 32'd0);
    @(negedge clk);
    chk("clrr.c2_done", done, 32'd1);
    chk("clrr.c2_rb", reset_ban_registros, 32'd0);
    chk("clrr.c2_skip", skipped, 32'd0);
    chk("clrr.c2_en", en, 32'd0);
    chk("clrr.c2_ret", retired, {24'd0, exp_retired});
    @(negedge clk);
    chk("clrr.c3_ready", bus.instr_ready, 32'd1);
    chk("clrr.c3_en", en, 32'd0);

    // Reset during WRITEBACK
    bus.instr       = {5'h06, 4'd2, 4'd3, 3'b000};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("rstwb.c2_en", en, 32'd1);
    @(negedge clk);
    chk("rstwb.c3_hab", hab_escrita, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstwb.hab", hab_escrita, 32'd0);
    chk("rstwb.en", en, 32'd0);
    chk("rstwb.done", done, 32'd0);
    chk("rstwb.busy", busy, 32'd0);
    chk("rstwb.ret", retired, 32'd0);
    chk("rstwb.ready", bus.instr_ready, 32'd0);
    reset       = 1'b0;
    exp_retired = 8'd0;
    @(negedge clk);
    chk("rstwb.after_ready", bus.instr_ready, 32'd1);
    chk("rstwb.after_done", done, 32'd0);

    // 256 back-to-back instructions with instr_valid held high
    bus.instr       = {5'h03, 4'd5, 4'd6, 3'b000};
    flags_zcso      = 4'b0000;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 1400; c++) begin
      if (done_cnt == 256) break;
      chk("b2b.ready_busy", {31'd0, bus.instr_ready & busy}, 32'd0);
      if (done) begin
        done_cnt++;
        chk("b2b.retired", retired, {24'd0, 8'(done_cnt)});
      end
      if (bus.instr_ready && bus.instr_valid) begin
        acc_cnt++;
        if (last_acc >= 0) chk("b2b.gap", c - last_acc, 32'd5);
        last_acc = c;
      end
      @(negedge clk);
      if (acc_cnt == 256) bus.instr_valid = 1'b0;
    end
    chk("b2b.accepted", acc_cnt, 32'd256);
    chk("b2b.dones", done_cnt, 32'd256);
    chk("b2b.wrap", retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uc_bloco.md
# uc_bloco

Control unit that sequences the register-bank / ULA / flag-register datapath (BLOCO). It accepts one encoded instruction at a time over a valid/ready handshake. It evaluates an optional flag condition against the current ZCSO flags, then drives register selects, ULA operation code, datapath enable and write strobe over fixed multi-cycle phases. It also sequences register-bank and flag clears and counts retired instructions.

## Interface
- end_registros, 4, register address width; instruction width is 5 + 2*end_registros + 3 (16 at default)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; returns block to IDLE
- instr_valid  input  1  instruction offered
- instr_ready  output  1  high only in IDLE and while reset is low
- instr  input  5+2*end_registros+3  [MSB..]: op[4:0], sa[end_registros-1:0], sb[end_registros-1:0], cond[2:0]
- clear_regs  input  1  request register-bank clear; sampled only in IDLE
- flags_zcso  input  4  flag register contents: bit3 Z, bit2 C, bit1 S, bit0 O
- sel_sa  output  end_registros  register A / destination select
- sel_sb  output  end_registros  register B select
- controle_operacao  output  5  ULA operation code
- en  output  1  datapath enable
- hab_escrita  output  1  register-bank write strobe
- reset_ban_registros  output  1  one-cycle register-bank clear pulse
- reset_flags  output  1  one-cycle flag-register clear pulse
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- skipped  output  1  valid with done; 1 when condition failed
- retired  output  8  count of instructions that executed (not skipped, not clears); wraps 255->0

## Operation
- States: IDLE, DECODE, EXECUTE, WRITEBACK, CLRF, CLRR, DONE.
- IDLE:
  - If clear_regs=1, go to CLRR. clear_regs has priority over instr_valid; instr_ready still reads 1 in this cycle, but instr is not accepted.
  - Else, if instr_valid=1, latch instr into the internal instruction register and go to DECODE.
- DECODE evaluates cond against flags_zcso as sampled in this cycle:
  - 000: always
  - 001: Z=1
  - 010: Z=0
  - 011: C=1
  - 100: S=1
  - 101: O=1
  - 110: never (NOP)
  - 111: clear flags
- DECODE transitions:
  - Condition true: go to EXECUTE.
  - Condition false (including 110): go to DONE with skipped=1.
  - Cond 111: go to CLRF.
- EXECUTE:
  - sel_sa, sel_sb and controle_operacao come from the latched instr; en=1; hab_escrita=0.
  - The flag register captures ULA flags at the end of this cycle.
- WRITEBACK: same selects and opcode held, en=1, hab_escrita=1. Then DONE, with retired incremented on that edge.
- CLRF: reset_flags=1 for one cycle, then DONE with skipped=0; retired unchanged.
- CLRR: reset_ban_registros=1 for one cycle, then DONE with skipped=0; retired unchanged.
- DONE: done=1 for one cycle, then IDLE.
- Output gating:
  - Outside EXECUTE/WRITEBACK: sel_sa, sel_sb and controle_operacao are 0, and en=0, hab_escrita=0.
  - The skipped register holds its value until the next DONE.
- instr_valid is ignored outside IDLE; instr changes while busy have no effect.

## Timing
- Reset values:
  - Outputs: instr_ready=0 while reset is high, and every other output is 0, including skipped and retired.
  - Internals: state=IDLE, instruction register=0.
  - First cycle after reset deasserts: instr_ready=1.
- Cycle numbering, with cycle 0 = acceptance cycle (instr_valid & instr_ready):
  - Executed instruction: DECODE in cycle 1, EXECUTE in cycle 2, WRITEBACK in cycle 3, done in cycle 4, instr_ready=1 again in cycle 5. Throughput is one instruction per 5 cycles.
  - Skipped instruction: done in cycle 2, ready in cycle 3.
  - Flag clear: reset_flags in cycle 2, done in cycle 3.
  - Register clear: reset_ban_registros in cycle 1, done in cycle 2.
- Reset asserted in any state: next edge forces IDLE, and any in-flight strobe is dropped (no partial writeback). retired returns to 0.
- retired is 8-bit modular: 255 + 1 = 0, with no saturation.

## Test plan
- Reset, then instr op=5'h01, sa=3, sb=4, cond=000 -> en=1 in cycle 2; hab_escrita=1 only in cycle 3 with sel_sa=3, sel_sb=4, controle_operacao=1; done=1 and skipped=0 in cycle 4; retired=1.
- flags_zcso=4'b0000, cond=001 -> no en/hab_escrita pulse; done in cycle 2 with skipped=1; retired unchanged. Repeat with flags=4'b1000 -> executes.
- cond=111 -> reset_flags=1 exactly in cycle 2, done in cycle 3; clear_regs=1 in IDLE -> reset_ban_registros=1 for one cycle, done the next cycle; clear_regs and instr_valid together -> clear taken, instruction not accepted.
- Reset asserted during WRITEBACK -> hab_escrita=0 on the next cycle, state IDLE, retired=0, no done pulse.
- 256 back-to-back cond=000 instructions with instr_valid held high -> accepts exactly every 5 cycles; retired wraps to 0; instr_ready never high while busy=1.
